pipe_ctrl: RTL and testbench

Central pipeline control for the five-stage MIPS core. Watches hazard sources in ID and EX, tracks multi-cycle multiply/divide occupancy with an internal FSM, and drives the 2-bit flush code of each inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC write enable and next-PC select. The flush codes feed the inter-stage registers directly: 00 pass, 01 flush to zero, 10 hold.

---
 rtl/pipe_ctrl_if.sv | 45 ++++
 rtl/pipe_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs, flush/PC control outputs and performance
// counters of the central pipeline controller.
// master : the pipeline datapath side (drives hazard sources, consumes control)
// slave  : the pipe_ctrl side
interface pipe_ctrl_if;
    // hazard sources from ID and EX
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  ex_rt;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        id_jump;
    logic        md_start;
    logic        md_is_div;

    // inter-stage register control: 00 pass, 01 flush to zero, 10 hold
    logic [1:0]  if_id_flush;
    logic [1:0]  id_ex_flush;
    logic [1:0]  ex_mem_flush;
    logic [1:0]  mem_wb_flush;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        md_busy;
    logic        md_done;

    // performance counters
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    modport master (
        output id_rs, id_rt, ex_rt, ex_mem_read, ex_branch_taken,
               id_jump, md_start, md_is_div,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               pc_write, pc_sel, md_busy, md_done,
               stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_mem_read, ex_branch_taken,
               id_jump, md_start, md_is_div,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
               pc_write, pc_sel, md_busy, md_done,
               stall_count, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline control for the five-stage MIPS core.
// Resolves branch, load-use and jump hazards, holds the front of the pipe
// while a multiply/divide occupies EX, and drives the flush code of every
// inter-stage register together with the PC write enable and next-PC select.
//
// Optional feature: define PIPE_CTRL_STATS_EN to build the stall/flush
// performance counters; otherwise both counter outputs are tied to zero.
//
// Multiply/divide occupancy FSM
//   state | meaning
//   IDLE  | no multi-cycle op; md_start here is the first stall cycle
//   BUSY  | op in progress; r_cnt counts remaining stall cycles minus one
module pipe_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam logic [1:0] FL_PASS = 2'b00;
    localparam logic [1:0] FL_ZERO = 2'b01;
    localparam logic [1:0] FL_HOLD = 2'b10;

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_JMP  = 2'd2;

    // The start cycle itself is one stall cycle and the cnt==0 cycle is
    // another, so the counter is loaded with LAT-2.
    localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 2);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_LAT - 2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;

    logic        w_md_busy;
    logic        w_md_done;
    logic        w_load_use;

    logic        w_pc_write;
    logic [1:0]  w_pc_sel;
    logic [1:0]  w_if_id;
    logic [1:0]  w_id_ex;
    logic [1:0]  w_ex_mem;
    logic [1:0]  w_mem_wb;

    // FSM state and stall counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state, counter update and busy/done decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_busy   = 1'b0;
        w_md_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.md_start) begin
                    w_md_busy   = 1'b1;
                    w_cnt_nxt   = bus.md_is_div ? DIV_LOAD : MUL_LOAD;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // a new md_start while busy is ignored
                w_md_busy = 1'b1;
                if (r_cnt == 5'd0) begin
                    w_md_done   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    // A load in EX whose destination is a live (non-zero) source of ID
    assign w_load_use = bus.ex_mem_read
                      && (bus.ex_rt != 5'd0)
                      && ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));

    // Hazard priority: reset, multi-cycle stall, branch, load-use, jump
    always_comb begin
        w_pc_write = 1'b1;
        w_pc_sel   = PC_SEQ;
        w_if_id    = FL_PASS;
        w_id_ex    = FL_PASS;
        w_ex_mem   = FL_PASS;
        w_mem_wb   = FL_PASS;
        if (!rst) begin
            w_pc_write = 1'b0;
            w_if_id    = FL_ZERO;
            w_id_ex    = FL_ZERO;
            w_ex_mem   = FL_ZERO;
            w_mem_wb   = FL_ZERO;
        end else if (w_md_busy) begin
            // freeze IF..EX, drain a bubble into MEM, let WB retire
            w_pc_write = 1'b0;
            w_if_id    = FL_HOLD;
            w_id_ex    = FL_HOLD;
            w_ex_mem   = FL_ZERO;
        end else if (bus.ex_branch_taken) begin
            w_pc_sel   = PC_BR;
            w_if_id    = FL_ZERO;
            w_id_ex    = FL_ZERO;
        end else if (w_load_use) begin
            // bubble into EX; the next cycle the hazard is gone
            w_pc_write = 1'b0;
            w_if_id    = FL_HOLD;
            w_id_ex    = FL_ZERO;
        end else if (bus.id_jump) begin
            w_pc_sel   = PC_JMP;
            w_if_id    = FL_ZERO;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.pc_sel       = w_pc_sel;
    assign bus.if_id_flush  = w_if_id;
    assign bus.id_ex_flush  = w_id_ex;
    assign bus.ex_mem_flush = w_ex_mem;
    assign bus.mem_wb_flush = w_mem_wb;
    assign bus.md_busy      = rst & w_md_busy;
    assign bus.md_done      = rst & w_md_done;

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    // Stall and front-end flush counters, free-running with natural wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (!w_pc_write) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if ((w_if_id == FL_ZERO) || (w_id_ex == FL_ZERO)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;
`else
    assign bus.stall_count = 32'd0;
    assign bus.flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus a randomized run of pipe_ctrl
// against a cycle-level reference model of the hazard rules.
module tb_pipe_ctrl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 8;

    // observed vector: {pc_write, pc_sel, if_id, id_ex, ex_mem, mem_wb, busy, done}
    localparam logic [12:0] V_RESET = {1'b0, 2'd0, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0};
    localparam logic [12:0] V_NORM  = {1'b1, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [12:0] V_LU    = {1'b0, 2'd0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [12:0] V_BR    = {1'b1, 2'd1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [12:0] V_JMP   = {1'b1, 2'd2, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [12:0] V_MD    = {1'b0, 2'd0, 2'b10, 2'b10, 2'b01, 2'b00, 1'b1, 1'b0};
    localparam logic [12:0] V_MDD   = {1'b0, 2'd0, 2'b10, 2'b10, 2'b01, 2'b00, 1'b1, 1'b1};

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    // reference model state: stall cycles still owed after the current one
    int          m_remain;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] obs();
        return {bus.pc_write, bus.pc_sel, bus.if_id_flush, bus.id_ex_flush,
                bus.ex_mem_flush, bus.mem_wb_flush, bus.md_busy, bus.md_done};
    endfunction

    function automatic logic [12:0] model_out();
        logic lu;
        if (!rst) return V_RESET;
        if (m_remain > 0) return (m_remain == 1) ? V_MDD : V_MD;
        if (bus.md_start) return V_MD;
        if (bus.ex_branch_taken) return V_BR;
        lu = bus.ex_mem_read && (bus.ex_rt != 0) &&
             ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
        if (lu) return V_LU;
        if (bus.id_jump) return V_JMP;
        return V_NORM;
    endfunction

    function automatic logic [63:0] model_counts();
`ifdef PIPE_CTRL_STATS_EN
        if (!rst) return 64'd0;
        return {m_stall, m_flush};
`else
        return 64'd0;
`endif
    endfunction

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] exrt,
                          input logic memrd, input logic br, input logic jmp,
                          input logic mds, input logic isdiv);
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.ex_rt           = exrt;
        bus.ex_mem_read     = memrd;
        bus.ex_branch_taken = br;
        bus.id_jump         = jmp;
        bus.md_start        = mds;
        bus.md_is_div       = isdiv;
    endtask

    task automatic model_clear();
        m_remain = 0;
        m_stall  = 32'd0;
        m_flush  = 32'd0;
    endtask

    // advance the model with the current inputs, then across the next rising edge
    task automatic tick();
        logic [12:0] e;
        e = model_out();
        if (!rst) begin
            model_clear();
        end else begin
            if (e[12] == 1'b0) m_stall = m_stall + 32'd1;
            if (e[9:8] == 2'b01 || e[7:6] == 2'b01) m_flush = m_flush + 32'd1;
            if (m_remain > 0) m_remain = m_remain - 1;
            else if (bus.md_start) m_remain = int'(bus.md_is_div ? DIV_LAT : MUL_LAT) - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        rst = 1'b0;
        model_clear();
        set_in(5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        got = obs();
        n_checks++;
        if (got !== V_RESET) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", got, V_RESET);
        end
        tick();
        tick();
        @(negedge clk);
        got = obs();
        n_checks++;
        if (got !== V_RESET) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected %h", got, V_RESET);
        end
        n_checks++;
        if ({bus.stall_count, bus.flush_count} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h expected 0", {bus.stall_count, bus.flush_count});
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_load_use();
        logic [12:0] exp_v [6];
        logic [12:0] got;
        exp_v[0] = V_LU; exp_v[1] = V_NORM; exp_v[2] = V_LU;
        exp_v[3] = V_NORM; exp_v[4] = V_NORM; exp_v[5] = V_LU;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                1: set_in(5'd8, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                2: set_in(5'd1, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                3: set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                4: set_in(5'd8, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                default: set_in(5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            @(negedge clk);
            got = obs();
            n_checks++;
            if (got !== exp_v[i]) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %h expected %h", i, got, exp_v[i]);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_branch_priority();
        logic [12:0] exp_v [3];
        logic [12:0] got;
        exp_v[0] = V_BR; exp_v[1] = V_BR; exp_v[2] = V_JMP;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_in(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                1: set_in(5'd4, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                default: set_in(5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            endcase
            @(negedge clk);
            got = obs();
            n_checks++;
            if (got !== exp_v[i]) begin
                n_fail++;
                $display("FAIL branch_prio[%0d]: got %h expected %h", i, got, exp_v[i]);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_multiply();
        logic [12:0] got;
        logic [12:0] e;
        for (int c = 1; c <= int'(MUL_LAT) + 1; c++) begin
            if (c == 1) set_in(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
            else        set_in(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
            e = (c < int'(MUL_LAT)) ? V_MD : (c == int'(MUL_LAT)) ? V_MDD : V_NORM;
            @(negedge clk);
            got = obs();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL multiply cycle %0d: got %h expected %h", c, got, e);
            end
            tick();
        end
    endtask

    task automatic test_divide_ignored();
        logic [12:0] got;
        logic [12:0] e;
        for (int c = 1; c <= int'(DIV_LAT) + 1; c++) begin
            if (c == 1)
                set_in(0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
            else if (c <= int'(DIV_LAT))
                set_in(5'd3, 5'd3, 5'd3, 1'($urandom_range(0, 1)), 1'(c % 2), 1'((c / 2) % 2),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                set_in(0, 0, 0, 0, 0, 0, 0, 0);
            e = (c < int'(DIV_LAT)) ? V_MD : (c == int'(DIV_LAT)) ? V_MDD : V_NORM;
            @(negedge clk);
            got = obs();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL divide cycle %0d: got %h expected %h", c, got, e);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [12:0] got;
        set_in(0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        tick();
        set_in(0, 0, 0, 0, 1'b1, 0, 0, 0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        got = obs();
        n_checks++;
        if (got !== V_RESET) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %h expected %h", got, V_RESET);
        end
        n_checks++;
        if ({bus.stall_count, bus.flush_count} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_busy_counters: got %h expected 0", {bus.stall_count, bus.flush_count});
        end
        tick();
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            got = obs();
            n_checks++;
            if (got !== V_NORM) begin
                n_fail++;
                $display("FAIL after_reset_idle[%0d]: got %h expected %h", c, got, V_NORM);
            end
            tick();
            @(negedge clk);
        end
        tick();
    endtask

    task automatic test_stats();
        logic [63:0] got;
        logic [63:0] e;
        rst = 1'b0;
        model_clear();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        set_in(5'd8, 5'd0, 5'd8, 1'b1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 1'b1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < int'(MUL_LAT); c++) tick();
        @(negedge clk);
`ifdef PIPE_CTRL_STATS_EN
        e = {32'd5, 32'd2};
`else
        e = 64'd0;
`endif
        got = {bus.stall_count, bus.flush_count};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL stats_counts: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     got[63:32], got[31:0], e[63:32], e[31:0]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [12:0] got;
        logic [12:0] e;
        logic [63:0] gc;
        logic [63:0] ec;
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                   1'($urandom_range(0, 1)));
            @(negedge clk);
            got = obs();
            e   = model_out();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL random_outputs cycle %0d: got %h expected %h", c, got, e);
            end
            gc = {bus.stall_count, bus.flush_count};
            ec = model_counts();
            n_checks++;
            if (gc !== ec) begin
                n_fail++;
                $display("FAIL random_counters cycle %0d: got %h expected %h", c, gc, ec);
            end
            tick();
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        model_clear();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        test_reset();
        test_load_use();
        test_branch_priority();
        test_multiply();
        test_divide_ignored();
        test_reset_mid_busy();
        test_stats();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
